gpio_in_filter: RTL
===================

# gpio_in_filter

Input conditioning stage directly upstream of the GPIO controller: takes the 32 raw, asynchronous GPIO pad inputs, double-flop synchronises them to `mclk`, and per pin either passes them straight through or debounces them with a shared prescaled tick and per-pin stability counter. Its `pad_gpio_in` output drives the GPIO controller's `pad_gpio_in` input, so edge interrupts and data-in reads see only clean, synchronous levels.

## Interface
- `WD`, 32, number of GPIO pins filtered
- `CNT_W`, 4, width of per-pin stability counter and threshold
- `PSC_W`, 8, width of shared tick prescaler
- `mclk` in 1: system clock
- `h_reset` in 1: reset, synchronous, active-high
- `pad_gpio_raw` in WD: raw asynchronous pad inputs
- `cfg_filt_en` in WD: per-pin filter enable (1 = debounce, 0 = bypass)
- `cfg_filt_psc` in PSC_W: tick period minus one, in `mclk` cycles
- `cfg_filt_thr` in CNT_W: consecutive mismatching ticks required before the output flips, minus one
- `pad_gpio_in` out WD: filtered, registered pin levels to the GPIO controller
- `filt_change` out WD: one-cycle pulse per bit when `pad_gpio_in` bit toggles (macro-gated)

## Operation
- Sync: `sync1 <= pad_gpio_raw`, `sync2 <= sync1`. Every pin is always synchronised, enabled or not.
- Prescaler: `psc_cnt` free-runs. When `psc_cnt >= cfg_filt_psc`, `tick` = 1 for that cycle and `psc_cnt <= 0`. Otherwise `psc_cnt++`. Using `>=` means that lowering `cfg_filt_psc` mid-count never wraps through 2^PSC_W. `cfg_filt_psc = 0` gives a tick every cycle.
- Per pin i, bypass (`cfg_filt_en[i]=0`): `filt_q[i] <= sync2[i]` every cycle, and `cnt[i] <= 0`.
- Per pin i, filtered (`cfg_filt_en[i]=1`):
  - If `sync2[i] == filt_q[i]`: `cnt[i] <= 0` immediately, whether or not there is a tick. A glitch shorter than the threshold is discarded.
  - Else, on `tick`: if `cnt[i] == cfg_filt_thr`, then `filt_q[i] <= sync2[i]` and `cnt[i] <= 0`. Otherwise `cnt[i]++`.
  - Else, with no tick: `cnt[i]` holds.
- Per-pin states are IDLE (`cnt=0`, match) and PENDING (mismatch, counting). PENDING returns to IDLE on a match or on the flip.
- `cnt[i]` never exceeds `cfg_filt_thr`. If `cfg_filt_thr` is lowered below the current `cnt[i]`, the next tick flips the output: the compare is `cnt >= thr`.
- Enable 1→0: the counter clears and the output follows `sync2` on the next edge. Enable 0→1: filtering starts from the current `filt_q`, with the counter at 0.
- `pad_gpio_in = filt_q`. `filt_change = filt_q ^ filt_q_d`, with `filt_q_d` registered.
- All pins are independent. Only the prescaler is shared.

## Timing
- Reset (synchronous, `h_reset=1` at a rising edge): `sync1`, `sync2`, `filt_q`, `filt_q_d`, `cnt`, `psc_cnt` = 0. Therefore `pad_gpio_in = 0` and `filt_change = 0`.
- Reset asserted mid-count discards any pending flip. The first tick after release occurs `cfg_filt_psc+1` cycles later.
- Bypass latency: a raw change captured at edge k appears on `pad_gpio_in` after edge k+2 (3 flops). The `filt_change` pulse follows one cycle later, lasting one cycle.
- Filtered latency: 2 sync cycles, then (`cfg_filt_thr`+1) ticks of stable mismatch. Worst case is 2 + (thr+1)·(psc+1) cycles after the level settles.
- Simultaneous match and tick on the same edge: the match wins and the counter clears.
- There is no handshake. The outputs are level signals valid every cycle.

## Configuration
- `GPIO_FILT_CHANGE_EN` defined: the `filt_q_d` register and XOR are built, and `filt_change` pulses as described.
- `GPIO_FILT_CHANGE_EN` undefined: `filt_change` is tied to 0, no `filt_q_d` flops are built, and all other behaviour is identical.

## Test plan
- Reset: drive `pad_gpio_raw=32'hFFFF_FFFF` with `h_reset=1` for 3 cycles. Require `pad_gpio_in=0` and `filt_change=0`. After release with `cfg_filt_en=0`, require `pad_gpio_in=32'hFFFF_FFFF` at the 3rd edge.
- Bypass latency: `cfg_filt_en=0`, toggle raw bit 5 at edge k. Require `pad_gpio_in[5]` to change after edge k+2, and `filt_change[5]=1` for exactly one cycle after edge k+3.
- Debounce: `cfg_filt_en[0]=1`, `psc=3`, `thr=2`. Hold raw bit 0 high. Require `pad_gpio_in[0]` to rise only after 3 ticks, i.e. within 2+12 cycles, and not before the 3rd tick.
- Glitch rejection: same configuration, pulse raw bit 0 high for 6 cycles (less than 3 ticks). Require `pad_gpio_in[0]` to stay 0 and `cnt[0]` to return to 0.
- Dynamic config: mid-count, drop `psc` from 200 to 2 while `psc_cnt=100`. Require a tick the next cycle with no wrap. Lower `thr` from 7 to 1 while `cnt=4`. Require a flip at the next tick.
- Macro off: build without `GPIO_FILT_CHANGE_EN`, toggle all pins. Require `filt_change=0` always and `pad_gpio_in` timing identical to the macro-on build.

Source files
------------

// File: rtl/gpio_in_filter.sv
// Purpose : synchronise raw GPIO pads to mclk and optionally debounce each pin.
// Latency : bypass 3 cycles (2 sync + output flop); filtered 2 + (thr+1)*(psc+1) cycles worst case.
// Backpres: none, outputs are level signals valid every cycle.
//
// Optional feature macro: GPIO_FILT_CHANGE_EN. When it is defined, the per-pin change pulse
// output is built. When it is undefined, filt_change is tied to zero and no change-detect flops exist.

module gpio_in_filter #(
    parameter int WD    = 32,
    parameter int CNT_W = 4,
    parameter int PSC_W = 8
) (
    input  logic             mclk,
    input  logic             h_reset,
    input  logic [WD-1:0]    pad_gpio_raw,
    input  logic [WD-1:0]    cfg_filt_en,
    input  logic [PSC_W-1:0] cfg_filt_psc,
    input  logic [CNT_W-1:0] cfg_filt_thr,
    output logic [WD-1:0]    pad_gpio_in,
    output logic [WD-1:0]    filt_change
);

    // Synchroniser and prescaler state
    logic [WD-1:0]             r_sync1;
    logic [WD-1:0]             r_sync2;
    logic [PSC_W-1:0]          r_psc_cnt;

    // Per-pin filter state
    logic [WD-1:0]             r_filt_q;
    logic [WD-1:0][CNT_W-1:0]  r_cnt;

    // Next-state wires
    logic                      w_tick;
    logic [WD-1:0]             w_filt_q_nxt;
    logic [WD-1:0][CNT_W-1:0]  w_cnt_nxt;

    // Two-flop synchroniser; every pin is synchronised regardless of its enable.
    always_ff @(posedge mclk) begin
        if (h_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pad_gpio_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Shared tick: '>=' so that lowering the period mid-count ticks at once instead of wrapping.
    always_comb begin
        w_tick = (r_psc_cnt >= cfg_filt_psc);
    end

    // Free-running prescaler, restarted on every tick.
    always_ff @(posedge mclk) begin
        if (h_reset) begin
            r_psc_cnt <= '0;
        end else if (w_tick) begin
            r_psc_cnt <= '0;
        end else begin
            r_psc_cnt <= r_psc_cnt + PSC_W'(1);
        end
    end

    // Per-pin debounce: a match clears the counter (and beats a coincident tick); a mismatch
    // advances the counter one step per tick and flips the output once it reaches the threshold.
    // The '>=' compare makes a threshold lowered below the current count flip on the next tick.
    always_comb begin
        w_filt_q_nxt = r_filt_q;
        w_cnt_nxt    = '0;
        for (int i = 0; i < WD; i++) begin
            if (!cfg_filt_en[i]) begin
                w_filt_q_nxt[i] = r_sync2[i];
            end else if (r_sync2[i] != r_filt_q[i]) begin
                if (w_tick) begin
                    if (r_cnt[i] >= cfg_filt_thr) begin
                        w_filt_q_nxt[i] = r_sync2[i];
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    w_cnt_nxt[i] = r_cnt[i];
                end
            end
        end
    end

    // Filter output and counter registers.
    always_ff @(posedge mclk) begin
        if (h_reset) begin
            r_filt_q <= '0;
            r_cnt    <= '0;
        end else begin
            r_filt_q <= w_filt_q_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign pad_gpio_in = r_filt_q;

`ifdef GPIO_FILT_CHANGE_EN
    logic [WD-1:0] r_filt_q_d;
    logic [WD-1:0] r_filt_chg;

    // Change pulse: registered XOR of the output against its delayed copy, so the pulse
    // lands the cycle after pad_gpio_in moves and lasts exactly one cycle.
    always_ff @(posedge mclk) begin
        if (h_reset) begin
            r_filt_q_d <= '0;
            r_filt_chg <= '0;
        end else begin
            r_filt_q_d <= r_filt_q;
            r_filt_chg <= r_filt_q ^ r_filt_q_d;
        end
    end

    assign filt_change = r_filt_chg;
`else
    assign filt_change = '0;
`endif

endmodule
